// File: rtl/alu_pkg.sv
// Shared opcode and FSM-state definitions for the sequential calculator ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_REM = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CALC   = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

endpackage

// File: rtl/seq_muldiv_core.sv
// Unsigned W-bit iterative engine: shift-add multiply and restoring divide run side by side.
// Latency: W step cycles after load; outputs are final after the W-th step.
// Backpressure: none; advances only when step is high, load restarts it.
//
// Ports: clk, rst_n (async active-low); load captures mag_a/mag_b; step advances one
// iteration; product = mag_a*mag_b, remainder/quotient = mag_a / mag_b (magnitudes).
module seq_muldiv_core #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [W-1:0]     mag_a,
    input  logic [W-1:0]     mag_b,
    output logic [2*W-1:0]   product,
    output logic [W-1:0]     remainder,
    output logic [W-1:0]     quotient
);

    // Multiply: upper half accumulates, lower half holds the not-yet-consumed multiplier bits.
    logic [2*W-1:0] prod_r;
    logic [W-1:0]   mcand_r;
    // Divide: quo_r starts as the dividend and is shifted out MSB-first while quotient bits shift in.
    logic [W-1:0]   dvsr_r;
    logic [W-1:0]   rem_r;
    logic [W-1:0]   quo_r;

    logic [W:0]     add_sum;
    logic [W:0]     shifted;
    logic [W:0]     trial;

    assign add_sum = {1'b0, prod_r[2*W-1:W]} + (prod_r[0] ? {1'b0, mcand_r} : {(W+1){1'b0}});
    assign shifted = {rem_r, quo_r[W-1]};
    // rem_r < dvsr_r holds between steps, so the trial difference always fits in W+1 signed bits.
    assign trial   = shifted - {1'b0, dvsr_r};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_r  <= '0;
            mcand_r <= '0;
            dvsr_r  <= '0;
            rem_r   <= '0;
            quo_r   <= '0;
        end else if (load) begin
            prod_r  <= {{W{1'b0}}, mag_b};
            mcand_r <= mag_a;
            dvsr_r  <= mag_b;
            rem_r   <= '0;
            quo_r   <= mag_a;
        end else if (step) begin
            prod_r <= {add_sum, prod_r[W-1:1]};
            if (!trial[W]) begin
                rem_r <= trial[W-1:0];
                quo_r <= {quo_r[W-2:0], 1'b1};
            end else begin
                rem_r <= shifted[W-1:0];
                quo_r <= {quo_r[W-2:0], 1'b0};
            end
        end
    end

    assign product   = prod_r;
    assign remainder = rem_r;
    assign quotient  = quo_r;

endmodule

// File: rtl/seq_alu.sv
// Sequential signed ALU: add/sub in one pass, mul/rem via an iterative W-step engine.
// Latency: start-to-done 2 cycles for add/sub/divide-by-zero, W+2 cycles for mul/rem.
// Backpressure: start is only sampled in IDLE; a start while busy is dropped, never queued.
//
// Ports: clk, rst_n (async active-low); start/a/b/s request (s: 00 add, 01 sub, 10 mul, 11 rem);
// busy, done pulse, c (2W signed result), zeroflag, signflag, divbyzeroflag.
// Optional macro SEQ_ALU_QUOT_EN adds output q (W+1 bits, signed truncated quotient).
module seq_alu
    import alu_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = $clog2(W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     a,
    input  logic [W-1:0]     b,
    input  logic [1:0]       s,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   c,
    output logic             zeroflag,
    output logic             signflag,
    output logic             divbyzeroflag
`ifdef SEQ_ALU_QUOT_EN
    ,
    output logic [W:0]       q
`endif
);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [1:0]      s_r;

    logic [W-1:0]    mag_a;
    logic [W-1:0]    mag_b;
    logic [2*W-1:0]  product;
    logic [W-1:0]    remainder;
    logic [W-1:0]    quotient;
    logic            accept;

    // |-2^(W-1)| = 2^(W-1) still fits a W-bit unsigned magnitude.
    assign mag_a  = a[W-1] ? (~a + W'(1)) : a;
    assign mag_b  = b[W-1] ? (~b + W'(1)) : b;
    assign accept = (state == ST_IDLE) && start;

    seq_muldiv_core #(.W(W)) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (accept),
        .step      (state == ST_CALC),
        .mag_a     (mag_a),
        .mag_b     (mag_b),
        .product   (product),
        .remainder (remainder),
        .quotient  (quotient)
    );

    // Result assembly from latched operands and engine magnitudes.
    logic [W:0]      a_x;
    logic [W:0]      b_x;
    logic [W:0]      addsub;
    logic [2*W-1:0]  rem_ext;
    logic [2*W-1:0]  res;
    logic            res_dz;

    assign a_x     = {a_r[W-1], a_r};
    assign b_x     = {b_r[W-1], b_r};
    assign addsub  = (s_r == OP_SUB) ? (a_x - b_x) : (a_x + b_x);
    assign rem_ext = {{W{1'b0}}, remainder};

    always_comb begin
        res    = '0;
        res_dz = 1'b0;
        case (s_r)
            OP_ADD, OP_SUB: res = {{(W-1){addsub[W]}}, addsub};
            OP_MUL:         res = (a_r[W-1] ^ b_r[W-1]) ? (~product + (2*W)'(1)) : product;
            default: begin
                if (b_r == '0) begin
                    res_dz = 1'b1;
                end else begin
                    // Truncating division: remainder follows the dividend sign only.
                    res = a_r[W-1] ? (~rem_ext + (2*W)'(1)) : rem_ext;
                end
            end
        endcase
    end

`ifdef SEQ_ALU_QUOT_EN
    logic [W:0] quo_ext;
    logic [W:0] quo_res;

    assign quo_ext = {1'b0, quotient};

    always_comb begin
        quo_res = '0;
        if (s_r == OP_REM && b_r != '0) begin
            quo_res = (a_r[W-1] ^ b_r[W-1]) ? (~quo_ext + (W+1)'(1)) : quo_ext;
        end
    end
`else
    logic unused_quotient;
    assign unused_quotient = ^quotient;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            a_r           <= '0;
            b_r           <= '0;
            s_r           <= OP_ADD;
            busy          <= 1'b0;
            done          <= 1'b0;
            c             <= '0;
            zeroflag      <= 1'b0;
            signflag      <= 1'b0;
            divbyzeroflag <= 1'b0;
`ifdef SEQ_ALU_QUOT_EN
            q             <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_r  <= a;
                        b_r  <= b;
                        s_r  <= s;
                        cnt  <= '0;
                        busy <= 1'b1;
                        // Only real mul/rem need engine iterations; rem by zero short-circuits.
                        if (s == OP_MUL || (s == OP_REM && b != '0)) begin
                            state <= ST_CALC;
                        end else begin
                            state <= ST_FINISH;
                        end
                    end
                end
                ST_CALC: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(W - 1)) begin
                        state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    c             <= res;
                    zeroflag      <= (res == '0);
                    signflag      <= res[2*W-1];
                    divbyzeroflag <= res_dz;
`ifdef SEQ_ALU_QUOT_EN
                    q             <= quo_res;
`endif
                    done          <= 1'b1;
                    busy          <= 1'b0;
                    state         <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, sequential successor of the 3-bit signed calculator ALU.
- Operands are W-bit two's-complement values; the result is 2W bits; opcodes and flag semantics are unchanged.
- Add and sub complete in one cycle. Multiply (shift-add) and remainder (restoring division) are iterative, taking W+1 cycles.
- Sits between the keypad/operand registers and the display driver; uses a start/done handshake.

Parameters:
- W, 8, operand width in bits; legal range 3..16.
- CW, $clog2(W+1), iteration-counter width (derived; do not override).

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- start  in  1  one-cycle request; sampled only in IDLE.
- a  in  W  signed operand A (dividend / multiplicand).
- b  in  W  signed operand B (divisor / multiplier).
- s  in  2  opcode: 00 add, 01 sub, 10 mul, 11 rem.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; the result and flags are valid from this cycle.
- c  out  2W  signed result, sign-extended to 2W bits.
- zeroflag  out  1  c == 0.
- signflag  out  1  c[2W-1].
- divbyzeroflag  out  1  s==11 and b==0.

Behaviour:
- Clocking and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: all outputs 0; FSM in IDLE; counter 0.
- States: IDLE, CALC, FINISH.
- IDLE:
  - On start, latch a, b and s into internal registers.
  - s=00/01, or s=11 with b==0, goes directly to FINISH.
  - s=10/11 otherwise goes to CALC with counter=0.
- CALC:
  - One iteration per cycle; counter increments each cycle.
  - After W iterations, go to FINISH.
- FINISH:
  - Register c and the flags, pulse done, return to IDLE.
  - busy is low again in the same cycle as done.
- Latency (start edge to done high):
  - add/sub/divide-by-zero: 2 cycles.
  - mul/rem: W+2 cycles.
- Operand and command handling:
  - Operands are sampled only at start; later changes to a, b or s have no effect on the running operation.
  - start while busy is ignored; it is neither queued nor aborted.
  - c and the flags hold their values until the next FINISH.
  - A new start is accepted in the same cycle done is high.
- Arithmetic:
  - add/sub: computed at W+1 bits, then sign-extended; never overflows.
  - mul: full 2W signed product. Operands are converted to magnitudes, the magnitudes multiplied, then the result negated if the operand signs differ.
  - -2^(W-1) * -2^(W-1) = 2^(2W-2), which is representable.
  - rem: truncating division. The magnitude remainder takes the sign of the dividend; the divisor sign is ignored.
- Divide by zero: c=0, zeroflag=1, divbyzeroflag=1; no CALC cycles.
- divbyzeroflag is cleared on the next completed non-faulting operation.
- Reset asserted mid-CALC: abort immediately; outputs return to 0 and no done pulse is produced.

Optional Feature:
- Macro: SEQ_ALU_QUOT_EN.
- Defined:
  - Adds output port q (W+1 bits, signed), the truncated quotient, produced by the same division pass.
  - q = 0 on divide-by-zero and for non-rem opcodes; reset value 0.
  - W+1 bits because -2^(W-1) / -1 = +2^(W-1).
- Undefined: port q is absent; the remainder path is unchanged.

Decomposition:
- Package alu_pkg:
  - Opcode localparams OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_REM=2'b11.
  - FSM state encoding ST_IDLE/ST_CALC/ST_FINISH.
- One sub-module, seq_muldiv_core:
  - Unsigned W-bit iterative engine: shift-add multiply or restoring divide, one step per enable.
  - Outputs product, remainder and quotient magnitudes.
- seq_alu owns the FSM, sign handling, add/sub and flags.

Test Plan:
- W=8, add a=127, b=1 -> done at start+2, c=16'h0080, signflag=0, zeroflag=0.
- W=8, sub a=-128, b=1 -> c=16'hFF7F (-129), signflag=1.
- W=8, mul a=-128, b=-128 -> busy for 9 cycles, done at start+10, c=16'h4000. Also a=-3, b=5 -> c=16'hFFF1.
- W=8, rem a=-7, b=3 -> c=16'hFFFF (-1), signflag=1. With SEQ_ALU_QUOT_EN: q=-2. Also a=7, b=-3 -> c=1.
- W=8, rem a=5, b=0 -> done at start+2, c=0, zeroflag=1, divbyzeroflag=1. Follow with add 1+1 -> divbyzeroflag=0, c=2.
- Pulse start mid-mul (ignored; result unchanged). Then assert rst_n=0 during CALC -> outputs 0 immediately, no done pulse; first start after release completes normally.
